// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: sequences FP16 operand pairs into an external
// multi-cycle MAC and accumulates one dot product per in_last-terminated run.
// Ports: clk, nRST (async active-low); in_* valid/ready operand stream with
//   acc_init sampled on the first pair; mac_start plus registered mac_*
//   operands to the MAC, mac_out_accumulate back; out_* valid/ready result
//   carrying result, saturating pair count and sticky infinity flag.
module mac_operand_sequencer #(
  parameter int MAC_LATENCY = 4
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_value,
  input  logic [15:0] in_weight,
  input  logic        in_last,
  input  logic [15:0] acc_init,
  output logic        mac_start,
  output logic [15:0] mac_in_value,
  output logic [15:0] mac_weight,
  output logic [15:0] mac_in_accumulate,
  input  logic [15:0] mac_out_accumulate,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [7:0]  out_count,
  output logic        out_ovf
);

  localparam int WW = $clog2(MAC_LATENCY) + 1;
  localparam logic [WW-1:0] WLOAD = WW'(MAC_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [15:0]   val_q;
  logic [15:0]   wgt_q;
  logic          last_q;
  logic [15:0]   acc_q;
  logic [7:0]    cnt_q;
  logic          ovf_q;
  logic          first_q;
  logic [WW-1:0] wcnt;

  logic hs;
  logic cap;

  assign hs  = in_valid & in_ready;
  // The MAC result is valid in the last WAIT cycle only.
  assign cap = (state == WAIT) && (wcnt == WW'(1));

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (hs) state_nx = ISSUE;
      ISSUE: state_nx = WAIT;
      WAIT:  if (cap) state_nx = last_q ? OUT : IDLE;
      OUT:   if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    // in_ready is gated by nRST so it stays low while reset is held.
    in_ready  = (state == IDLE) & nRST;
    mac_start = (state == ISSUE);
    out_valid = (state == OUT);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      val_q   <= '0;
      wgt_q   <= '0;
      last_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      first_q <= 1'b1;
      wcnt    <= '0;
    end else begin
      if (hs) begin
        val_q  <= in_value;
        wgt_q  <= in_weight;
        last_q <= in_last;
        if (first_q) begin
          acc_q   <= acc_init;
          cnt_q   <= 8'd1;
          ovf_q   <= 1'b0;
          first_q <= 1'b0;
        end else if (cnt_q != 8'hFF) begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
      if (state == ISSUE)
        wcnt <= WLOAD;
      else if (state == WAIT && wcnt != '0)
        wcnt <= wcnt - WW'(1);
      if (cap) begin
        acc_q <= mac_out_accumulate;
        // +inf and -inf differ only in the sign bit.
        if (mac_out_accumulate[14:0] == 15'h7C00)
          ovf_q <= 1'b1;
      end
      if (state == OUT && out_ready)
        first_q <= 1'b1;
    end
  end

  assign mac_in_value      = val_q;
  assign mac_weight        = wgt_q;
  assign mac_in_accumulate = acc_q;
  assign out_result        = acc_q;
  assign out_count         = cnt_q;
  assign out_ovf           = ovf_q;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// tb_mac_operand_sequencer: randomized and directed bench with an FP16
// MAC model and a dot-product reference model.
module tb_mac_operand_sequencer;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_value;
  logic [15:0] in_weight;
  logic        in_last;
  logic [15:0] acc_init;
  logic        mac_start;
  logic [15:0] mac_in_value;
  logic [15:0] mac_weight;
  logic [15:0] mac_in_accumulate;
  logic [15:0] mac_out_accumulate;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [7:0]  out_count;
  logic        out_ovf;

  mac_operand_sequencer #(.MAC_LATENCY(L)) dut (
    .clk(clk),
    .nRST(nRST),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_value(in_value),
    .in_weight(in_weight),
    .in_last(in_last),
    .acc_init(acc_init),
    .mac_start(mac_start),
    .mac_in_value(mac_in_value),
    .mac_weight(mac_weight),
    .mac_in_accumulate(mac_in_accumulate),
    .mac_out_accumulate(mac_out_accumulate),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_count(out_count),
    .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic real p2(input int n);
    real r;
    r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real r;
    int e;
    e = int'(h[14:10]);
    if (e == 31) r = 1.0e30;
    else if (e == 0) r = real'(int'(h[9:0])) * p2(-24);
    else r = real'(int'(h[9:0]) + 1024) * p2(e - 25);
    return h[15] ? -r : r;
  endfunction

  function automatic int rne(input real x);
    int q;
    real f;
    q = $rtoi(x);
    f = x - real'(q);
    if (f > 0.5 || (f == 0.5 && q[0])) q++;
    return q;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    logic s;
    real a;
    int e;
    int m;
    s = (r < 0.0);
    a = s ? -r : r;
    if (a >= 65520.0) return {s, 15'h7C00};
    if (a < p2(-14)) begin
      m = rne(a * p2(24));
      return {s, 15'(m)};
    end
    e = 30;
    while (e > 1 && a < p2(e - 15)) e--;
    m = rne(a * p2(25 - e));
    if (m >= 2048) begin
      e++;
      m = 1024;
    end
    if (e > 30) return {s, 15'h7C00};
    return {s, 5'(e), 10'(m - 1024)};
  endfunction

  function automatic logic [15:0] fma(input logic [15:0] a, b, c);
    return r2h(h2r(a) * h2r(b) + h2r(c));
  endfunction

  // MAC model: result visible only in the cycle MAC_LATENCY-1 after start.
  int mk;
  logic [15:0] ma, mb, mc;
  always @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      mk <= 0;
      ma <= '0;
      mb <= '0;
      mc <= '0;
    end else begin
      if (mk == L - 1)
        check("mac_operands_held",
              {mac_in_value, mac_weight, mac_in_accumulate}, {ma, mb, mc});
      if (mac_start) begin
        mk <= 1;
        ma <= mac_in_value;
        mb <= mac_weight;
        mc <= mac_in_accumulate;
      end else if (mk == L - 1) mk <= 0;
      else if (mk != 0) mk <= mk + 1;
    end
  end
  assign mac_out_accumulate = (mk == L - 1) ? fma(ma, mb, mc) : 16'h5555;

  logic [15:0] qv[$];
  logic [15:0] qw[$];

  function automatic void model(input logic [15:0] init,
                                output logic [15:0] r,
                                output logic [7:0] c, output logic o);
    r = init;
    o = 1'b0;
    foreach (qv[i]) begin
      r = fma(qv[i], qw[i], r);
      if (r == 16'h7C00 || r == 16'hFC00) o = 1'b1;
    end
    c = (qv.size() > 255) ? 8'd255 : 8'(qv.size());
  endfunction

  task automatic send(input logic [15:0] v, w, ai, input logic last,
                      output int t);
    in_value = v;
    in_weight = w;
    acc_init = ai;
    in_last = last;
    in_valid = 1'b1;
    t = -1;
    for (int k = 0; k < 100 && t < 0; k++) begin
      @(negedge clk);
      if (in_ready) t = cyc;
    end
    if (t < 0) begin
      check("handshake_timeout", 1, 0);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_value = 16'($urandom);
    in_weight = 16'($urandom);
    in_last = 1'($urandom);
    acc_init = 16'($urandom);
    check("mac_start_pulse", mac_start, 1);
    @(posedge clk);
    #1;
    check("mac_start_single", mac_start, 0);
  endtask

  task automatic get_result(input int hold, input int tlast,
                            output logic [15:0] r, output logic [7:0] c,
                            output logic o);
    int tv;
    tv = -1;
    r = '0;
    c = '0;
    o = 1'b0;
    for (int k = 0; k < 100 && tv < 0; k++) begin
      @(negedge clk);
      if (out_valid) tv = cyc;
    end
    if (tv < 0) begin
      check("out_valid_timeout", 1, 0);
      return;
    end
    check("out_valid_latency", tv, tlast + L + 1);
    r = out_result;
    c = out_count;
    o = out_ovf;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_value = 16'($urandom);
      in_weight = 16'($urandom);
      in_last = 1'b1;
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_outputs", {out_result, out_count, out_ovf}, {r, c, o});
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("accept_out_valid", out_valid, 0);
    check("accept_in_ready", in_ready, 1);
  endtask

  task automatic run_dp(input logic [15:0] init, input int hold,
                        output logic [15:0] r, output logic [7:0] c,
                        output logic o);
    int t;
    int tprev;
    tprev = -1;
    t = -1;
    foreach (qv[i]) begin
      send(qv[i], qw[i], (i == 0) ? init : 16'($urandom),
           i == qv.size() - 1, t);
      if (tprev >= 0 && t >= 0) check("in_ready_return", t, tprev + L + 1);
      tprev = t;
    end
    get_result(hold, t, r, c, o);
  endtask

  task automatic run_model(input string tag, input logic [15:0] init,
                           input int hold);
    logic [15:0] r, er;
    logic [7:0] c, ec;
    logic o, eo;
    model(init, er, ec, eo);
    run_dp(init, hold, r, c, o);
    check({tag, "_result"}, r, er);
    check({tag, "_count"}, c, ec);
    check({tag, "_ovf"}, o, eo);
  endtask

  logic [15:0] r;
  logic [7:0] c;
  logic o;
  int t;
  logic seen;

  function automatic logic [15:0] rnd_fp();
    return {1'($urandom), 5'($urandom_range(13, 16)), 10'($urandom)};
  endfunction

  initial begin
    in_valid = 1'b0;
    in_value = '0;
    in_weight = '0;
    in_last = 1'b0;
    acc_init = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_mac_start", mac_start, 0);
    check("rst_outputs", {out_result, out_count, out_ovf}, 0);
    check("rst_mac_ops",
          {mac_in_value, mac_weight, mac_in_accumulate}, 0);
    @(negedge clk);
    nRST = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", in_ready, 1);

    qv = '{16'h3C00, 16'h4200};
    qw = '{16'h4000, 16'h3800};
    run_dp(16'h0000, 0, r, c, o);
    check("dp2_result", r, 16'h4300);
    check("dp2_count", c, 2);
    check("dp2_ovf", o, 0);

    qv = '{16'h4000};
    qw = '{16'h4000};
    run_dp(16'h3C00, 0, r, c, o);
    check("single_result", r, 16'h4500);
    check("single_count", c, 1);

    qv = '{16'h7800};
    qw = '{16'h7800};
    run_dp(16'h0000, 0, r, c, o);
    check("inf_result", r, 16'h7C00);
    check("inf_ovf", o, 1);
    qv = '{16'h3C00};
    qw = '{16'h3C00};
    run_dp(16'h0000, 0, r, c, o);
    check("after_inf_result", r, 16'h3C00);
    check("after_inf_ovf", o, 0);

    qv = '{16'h3C00, 16'h4000, 16'hC000};
    qw = '{16'h3C00, 16'h3800, 16'h3C00};
    run_model("backpressure", 16'h4000, 10);

    send(16'h3C00, 16'h3C00, 16'h0000, 1'b0, t);
    send(16'h4000, 16'h4000, 16'h1234, 1'b0, t);
    nRST = 1'b0;
    #1;
    check("abort_mac_start", mac_start, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    nRST = 1'b1;
    @(posedge clk);
    #1;
    check("abort_release_ready", in_ready, 1);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_out_valid", seen, 0);
    @(posedge clk);
    #1;
    qv = '{16'h4000};
    qw = '{16'h4000};
    run_dp(16'h0000, 0, r, c, o);
    check("post_abort_result", r, 16'h4400);
    check("post_abort_count", c, 1);

    qv.delete();
    qw.delete();
    for (int i = 0; i < 300; i++) begin
      qv.push_back(16'h0000);
      qw.push_back(16'h0000);
    end
    run_dp(16'h0000, 0, r, c, o);
    check("sat_count", c, 255);
    check("sat_result", r, 16'h0000);

    for (int n = 0; n < 25; n++) begin
      int len;
      len = $urandom_range(1, 8);
      qv.delete();
      qw.delete();
      for (int i = 0; i < len; i++) begin
        qv.push_back(rnd_fp());
        qw.push_back(rnd_fp());
      end
      run_model("rand", rnd_fp(), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
